// File: rtl/sm_ext_out_capture_if.sv
// Drain-side handshake for sm_ext_out_capture: head entry plus valid/ready.
// master drives the data toward the consumer; slave is the consumer.
interface sm_ext_out_capture_if #(
  parameter int unsigned DW = 24
);
  logic [DW-1:0] outData;
  logic          outValid;
  logic          outReady;

  modport master (
    output outData,
    output outValid,
    input  outReady
  );

  modport slave (
    input  outData,
    input  outValid,
    output outReady
  );
endinterface

// File: rtl/sm_ext_out_capture.sv
// Logs every change on the CPU extOutput port with a cycle timestamp into a
// first-word-fall-through FIFO that a host drains through a valid/ready interface.
module sm_ext_out_capture #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        extOutput,
  input  logic                     capEnable,
  sm_ext_out_capture_if.master     out_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clearOverflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = TS_W + DATA_W;
  localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [DATA_W-1:0] prev_q;
  logic [AW:0]       wr_cnt_q, wr_cnt_d;
  logic [AW:0]       rd_cnt_q, rd_cnt_d;
  logic              overflow_q, overflow_d;
  logic [EW-1:0]     mem_q [DEPTH];

  logic        cap_event;
  logic [AW:0] level_w;
  logic        empty, full, pop, push, drop;

  always_comb begin
    ts_d      = ts_q + 1'b1;
    cap_event = capEnable && (extOutput != prev_q);
    // Extra pointer bit lets full (DEPTH) and empty (0) differ.
    level_w   = wr_cnt_q - rd_cnt_q;
    empty     = (level_w == '0);
    full      = (level_w == FullLevel);
    pop       = !empty && out_if.outReady;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    push      = cap_event && (!full || pop);
    drop      = cap_event && full && !pop;
    wr_cnt_d  = wr_cnt_q + {{AW{1'b0}}, push};
    rd_cnt_d  = rd_cnt_q + {{AW{1'b0}}, pop};
    // Set wins over a simultaneous clear.
    overflow_d = drop | (overflow_q & ~clearOverflow);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q       <= '0;
      prev_q     <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      prev_q     <= extOutput;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: outData is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_cnt_q[AW-1:0]] <= {ts_q, extOutput};
    end
  end

  always_comb begin
    out_if.outValid = !empty;
    out_if.outData  = empty ? '0 : mem_q[rd_cnt_q[AW-1:0]];
    level           = level_w;
    overflow        = overflow_q;
  end

endmodule

// File: tb/tb_sm_ext_out_capture.sv
// Scoreboard bench for sm_ext_out_capture: expected entries are queued as changes
// are driven and compared against the FIFO head every cycle.
module tb_sm_ext_out_capture;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TS_W   = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned EW     = TS_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] ext_out;
  logic              cap_en;
  logic              clr_ovf;
  logic [3:0]        level;
  logic              overflow;

  sm_ext_out_capture_if #(.DW(EW)) out_if ();

  sm_ext_out_capture #(
    .DATA_W(DATA_W),
    .TS_W  (TS_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .extOutput    (ext_out),
    .capEnable    (cap_en),
    .out_if       (out_if),
    .level        (level),
    .overflow     (overflow),
    .clearOverflow(clr_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0]     sb_q[$];
  logic [TS_W-1:0]   m_ts;
  logic [DATA_W-1:0] m_prev;
  logic              m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: check outputs against the model, advance the model
  // across the next rising edge, then return at the following falling edge.
  task automatic step(input logic [7:0] e, input logic c, input logic r, input logic cl);
    logic pop, full, ev;
    ext_out         = e;
    cap_en          = c;
    out_if.outReady = r;
    clr_ovf         = cl;
    #1;
    check_eq("level", 32'(level), 32'(sb_q.size()));
    check_eq("outValid", 32'(out_if.outValid), 32'(sb_q.size() != 0));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    if (sb_q.size() != 0) check_eq("outData", 32'(out_if.outData), 32'(sb_q[0]));
    else                  check_eq("outData_empty", 32'(out_if.outData), 32'h0);
    full = (sb_q.size() == int'(DEPTH));
    pop  = (sb_q.size() != 0) && r;
    ev   = c && (e != m_prev);
    if (pop) void'(sb_q.pop_front());
    if (ev && (!full || pop)) sb_q.push_back({m_ts, e});
    if (ev && full && !pop) m_ovf = 1'b1;
    else if (cl)            m_ovf = 1'b0;
    m_prev = e;
    m_ts   = m_ts + 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    ext_out         = 8'h5A;
    cap_en          = 1'b1;
    out_if.outReady = 1'b0;
    clr_ovf         = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_outValid", 32'(out_if.outValid), 32'h0);
    check_eq("rst_outData", 32'(out_if.outData), 32'h0);
    check_eq("rst_level", 32'(level), 32'h0);
    check_eq("rst_overflow", 32'(overflow), 32'h0);
    rst = 1'b0;
    sb_q.delete();
    m_ts   = '0;
    m_prev = '0;
    m_ovf  = 1'b0;
  endtask

  initial begin
    logic [7:0] e;
    do_reset();

    // First cycle after reset: 0x5A differs from the cleared prev register.
    step(8'h5A, 1'b1, 1'b0, 1'b0);
    check_eq("first_valid", 32'(out_if.outValid), 32'h1);
    check_eq("first_data", 32'(out_if.outData), 32'h00005A);

    while (m_ts != 16'd10) step(8'h00, 1'b0, 1'b1, 1'b0);
    step(8'h11, 1'b1, 1'b0, 1'b0);
    step(8'h22, 1'b1, 1'b0, 1'b0);
    check_eq("two_level", 32'(level), 32'h2);
    check_eq("two_head", 32'(out_if.outData), {8'h0, 16'd10, 8'h11});
    repeat (3) step(8'h22, 1'b1, 1'b1, 1'b0);
    check_eq("two_drained", 32'(out_if.outValid), 32'h0);

    // Nine changes into eight slots: the ninth is dropped.
    for (int i = 1; i <= 9; i++) step(8'(i), 1'b1, 1'b0, 1'b0);
    check_eq("full_level", 32'(level), 32'h8);
    check_eq("full_ovf", 32'(overflow), 32'h1);
    repeat (9) step(8'h09, 1'b1, 1'b1, 1'b0);
    check_eq("full_drained", 32'(out_if.outValid), 32'h0);
    step(8'h09, 1'b1, 1'b0, 1'b1);
    check_eq("ovf_cleared", 32'(overflow), 32'h0);

    // Push and pop together while full.
    for (int i = 1; i <= 8; i++) step(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0);
    step(8'h30, 1'b1, 1'b1, 1'b0);
    check_eq("pp_level", 32'(level), 32'h8);
    check_eq("pp_ovf", 32'(overflow), 32'h0);
    repeat (7) step(8'h30, 1'b1, 1'b1, 1'b0);
    check_eq("pp_last_level", 32'(level), 32'h1);
    check_eq("pp_last_data", 32'(out_if.outData[7:0]), 32'h30);
    step(8'h30, 1'b1, 1'b1, 1'b0);

    // Disabled capture ignores toggling; enabled capture logs every cycle.
    for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 8'hAB : 8'hEB, 1'b0, 1'b0, 1'b0);
    check_eq("dis_level", 32'(level), 32'h0);
    for (int i = 6; i < 10; i++) step((i % 2 == 0) ? 8'hAB : 8'hEB, 1'b1, 1'b0, 1'b0);
    check_eq("en_level", 32'(level), 32'h4);
    repeat (4) step(8'hEB, 1'b1, 1'b1, 1'b0);

    // Timestamp wrap.
    while (m_ts != 16'hFFFF) step(8'hEB, 1'b1, 1'b1, 1'b0);
    step(8'h01, 1'b1, 1'b0, 1'b0);
    step(8'h02, 1'b1, 1'b0, 1'b0);
    check_eq("wrap_level", 32'(level), 32'h2);
    check_eq("wrap_head", 32'(out_if.outData), {8'h0, 16'hFFFF, 8'h01});
    repeat (2) step(8'h02, 1'b1, 1'b1, 1'b0);

    // Overflow clear alone, then clear racing a drop.
    e = 8'h40;
    repeat (9) begin
      e = e + 8'h1;
      step(e, 1'b1, 1'b0, 1'b0);
    end
    check_eq("ovf_set", 32'(overflow), 32'h1);
    step(e, 1'b1, 1'b0, 1'b1);
    check_eq("ovf_clr_alone", 32'(overflow), 32'h0);
    step(8'h77, 1'b1, 1'b0, 1'b1);
    check_eq("ovf_clr_vs_drop", 32'(overflow), 32'h1);

    // Reset mid-operation discards entries asynchronously.
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", 32'(out_if.outValid), 32'h0);
    check_eq("midrst_level", 32'(level), 32'h0);
    check_eq("midrst_data", 32'(out_if.outData), 32'h0);
    check_eq("midrst_ovf", 32'(overflow), 32'h0);
    do_reset();
    repeat (3) step(8'h5A, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
